mem_bus_bridge: RTL and testbench
=================================

Name: mem_bus_bridge

Overview:
- CPU-side load/store unit that sits directly upstream of the word-wide Wishbone-style data memory slave.
- Converts byte, halfword and word accesses into word-wide bus cycles.
- Sub-word stores are done as read-modify-write; loads return extracted, sign- or zero-extended data.
- Byte lanes are little-endian: byte at addr[1:0]=0 is bits 7:0.

Parameters:
- ADDR_W, 32: CPU and bus byte-address width.
- DATA_W, 32: bus data width. Only 32 is supported.

Ports:
- clk in 1: single clock, rising edge.
- rst in 1: synchronous, active-high reset.
- cpu_req in 1: access request. Held high until cpu_ready.
- cpu_we in 1: 1 = store, 0 = load.
- cpu_size in 2: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- cpu_unsigned in 1: load zero-extends when 1, sign-extends when 0.
- cpu_addr in ADDR_W: byte address.
- cpu_wdata in 32: store data, right-aligned.
- cpu_rdata out 32: load result, registered.
- cpu_ready out 1: one-cycle completion pulse.
- cpu_misalign out 1: valid with cpu_ready. Access was rejected.
- wb_adr_o out ADDR_W: word-aligned byte address {addr[ADDR_W-1:2], 2'b00}.
- wb_dat_o out 32: write data to memory.
- wb_we_o out 1: write enable.
- wb_stb_o out 1: strobe.
- wb_dat_i in 32: read data. Valid the cycle after an acked read strobe.
- wb_ack_i in 1: slave acknowledge. Sampled while wb_stb_o=1.

Behaviour:
- Reset: state=IDLE; wb_stb_o, wb_we_o, cpu_ready, cpu_misalign = 0; cpu_rdata, wb_dat_o, wb_adr_o = 0.
- IDLE: when cpu_req=1, latch addr, size, we, unsigned and wdata.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0) -> state DONE with misalign=1. No bus cycle.
  - Load -> RD.
  - Word store -> WR.
  - Byte/half store -> RMW_RD.
- RD: stb=1, we=0. Stay until wb_ack_i=1, then -> CAPT.
- CAPT: stb=0. Take wb_dat_i, select lane by latched addr[1:0], extend to 32 bits into cpu_rdata -> DONE.
- WR: stb=1, we=1, wb_dat_o=wdata. Stay until wb_ack_i=1, then -> DONE.
- RMW_RD: stb=1, we=0. On ack -> MERGE.
- MERGE: stb=0. wb_dat_o = wb_dat_i with the addressed byte/half lane replaced by wdata[7:0] / wdata[15:0]. -> RMW_WR.
- RMW_WR: stb=1, we=1. On ack -> DONE.
- DONE: cpu_ready=1 for exactly one cycle.
  - cpu_misalign=1 only for rejected accesses.
  - cpu_rdata is held until the next load completes.
  - -> IDLE. A cpu_req seen in DONE is not sampled; it is accepted in the following IDLE cycle.
- Latency from the IDLE sample edge to cpu_ready, with ack immediate:
  - load 3 cycles
  - word store 2 cycles
  - sub-word store 4 cycles
  - misaligned 1 cycle
- Each wb_ack_i=0 cycle adds one cycle. wb_stb_o, wb_we_o, wb_adr_o and wb_dat_o are held stable while waiting.
- Half lanes: addr[1]=0 -> bits 15:0; addr[1]=1 -> bits 31:16.
- wb_stb_o is never high in two consecutive bus cycles of one RMW; MERGE always separates them.
- Reset mid-operation: next edge -> IDLE with stb=0. A write already acked is not undone, and no cpu_ready is issued for the aborted access.
- cpu_req dropping before cpu_ready is a protocol violation. The latched request still completes.

Decomposition:
- Shared package (mem_bus_pkg) holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state encoding;
  - function lane_extract(word, addr_lo, size, unsigned);
  - function lane_merge(word, wdata, addr_lo, size).
- One sub-module is natural: mem_lane_unit. It is combinational extract/merge logic, shared by CAPT and MERGE.
- The FSM stays in mem_bus_bridge.

Test Plan:
- Memory word 0x100 = 0x8899AABB. Load byte signed at 0x103 -> cpu_rdata=0xFFFFFF88, ready 3 cycles after sample. Unsigned -> 0x00000088.
- Load half signed at 0x102 -> 0xFFFF8899. At 0x100 -> 0xFFFFAABB. Load word at 0x100 -> 0x8899AABB.
- Store byte 0x5A at 0x101 over 0x8899AABB -> bus read, then write 0x88995ABB. Ready 4 cycles after sample, with exactly 2 strobes.
- Store half at 0x103 -> ready next cycle, misalign=1, wb_stb_o never asserted, memory unchanged. Word at 0x102 -> same.
- Slave holds wb_ack_i=0 for 3 cycles during a word store 0xDEADBEEF to 0x200 -> outputs stable, ready 5 cycles after sample, exactly one write.
- rst asserted during RMW_RD of a byte store -> next cycle IDLE with stb=0, no ready, memory unchanged. A following word load completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared encodings and byte-lane helpers for the CPU-to-Wishbone load/store bridge.
// Byte lanes are little-endian: addr[1:0]=0 selects bits 7:0.
package mem_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAPT,
    ST_WR,
    ST_RMW_RD,
    ST_MERGE,
    ST_RMW_WR,
    ST_DONE
  } state_e;

  // Size code 2'b11 is handled as a word everywhere, so only bit 1 is decoded.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  addr_lo,
                                               input logic [1:0]  size,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (addr_lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr_lo[1] ? word[31:16] : word[15:0];
    if (size[1])            r = word;
    else if (size == SZ_HALF) r = {{16{~is_unsigned & h[15]}}, h};
    else                    r = {{24{~is_unsigned & b[7]}}, b};
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  addr_lo,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    if (size[1]) begin
      r = wdata;
    end else if (size == SZ_HALF) begin
      if (addr_lo[1]) r[31:16] = wdata[15:0];
      else            r[15:0]  = wdata[15:0];
    end else begin
      case (addr_lo)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// Word-wide Wishbone-style data bus between the bridge (master) and memory (slave).
interface mem_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] wb_adr_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_we_o;
  logic              wb_stb_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/mem_lane_unit.sv
// Combinational byte/half lane logic: load extraction for CAPT and store merge for MERGE.
module mem_lane_unit
  import mem_bus_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] ext_o,
  output logic [31:0] merged_o
);

  assign ext_o    = lane_extract(rd_word_i, addr_lo_i, size_i, unsigned_i);
  assign merged_o = lane_merge(rd_word_i, wdata_i, addr_lo_i, size_i);

endmodule

// File: rtl/mem_bus_bridge.sv
// CPU load/store unit: turns byte/half/word accesses into word-wide bus cycles,
// using read-modify-write for sub-word stores.
module mem_bus_bridge
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_misalign,
  mem_bus_bridge_if.master  wb
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              mis_q, mis_d;
  logic [31:0]       ext_w, merged_w;
  logic              req_misaligned;

  mem_lane_unit u_lane (
    .rd_word_i (wb.wb_dat_i),
    .wdata_i   (wdata_q),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .ext_o     (ext_w),
    .merged_o  (merged_w)
  );

  assign req_misaligned = (cpu_size == SZ_HALF && cpu_addr[0]) ||
                          (cpu_size[1] && cpu_addr[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    dat_d   = dat_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          size_d  = cpu_size;
          uns_d   = cpu_unsigned;
          wdata_d = cpu_wdata;
          mis_d   = req_misaligned;
          if (req_misaligned) begin
            state_d = ST_DONE;
          end else if (!cpu_we) begin
            state_d = ST_RD;
          end else if (cpu_size[1]) begin
            dat_d   = cpu_wdata;
            state_d = ST_WR;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_RD:     if (wb.wb_ack_i) state_d = ST_CAPT;
      ST_CAPT: begin
        rdata_d = ext_w;
        state_d = ST_DONE;
      end
      ST_WR:     if (wb.wb_ack_i) state_d = ST_DONE;
      ST_RMW_RD: if (wb.wb_ack_i) state_d = ST_MERGE;
      // Read data arrives one cycle after the ack, so the merge lands here.
      ST_MERGE: begin
        dat_d   = merged_w;
        state_d = ST_RMW_WR;
      end
      ST_RMW_WR: if (wb.wb_ack_i) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      dat_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      dat_q   <= dat_d;
      mis_q   <= mis_d;
    end
  end

  assign wb.wb_stb_o  = (state_q == ST_RD) || (state_q == ST_WR) ||
                        (state_q == ST_RMW_RD) || (state_q == ST_RMW_WR);
  assign wb.wb_we_o   = (state_q == ST_WR) || (state_q == ST_RMW_WR);
  assign wb.wb_adr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign wb.wb_dat_o  = dat_q;
  assign cpu_rdata    = rdata_q;
  assign cpu_ready    = (state_q == ST_DONE);
  assign cpu_misalign = (state_q == ST_DONE) && mis_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge against a small word memory with programmable ack stall.
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_init;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_misalign;

  int          n_cmp = 0;
  int          n_err = 0;

  mem_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) wb ();

  mem_bus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_size    (cpu_size),
    .cpu_unsigned(cpu_unsigned),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ready   (cpu_ready),
    .cpu_misalign(cpu_misalign),
    .wb          (wb)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [31:0] mem [0:1023];
  logic [31:0] rd_q = 32'h0;
  int          stall_len = 0;
  int          wait_cnt = 0;
  int          n_wr = 0;
  int          n_rd = 0;
  int          n_stb = 0;
  int          unstable = 0;
  logic        prev_stall = 1'b0;
  logic [65:0] prev_snap = '0;

  assign wb.wb_ack_i = wb.wb_stb_o && (wait_cnt >= stall_len);
  assign wb.wb_dat_i = rd_q;

  always @(posedge clk) begin
    if (mem_init) begin
      mem[64]  <= 32'h8899AABB;
      mem[128] <= 32'h0;
    end else if (wb.wb_stb_o && wb.wb_ack_i) begin
      if (wb.wb_we_o) begin
        mem[wb.wb_adr_o[11:2]] <= wb.wb_dat_o;
        n_wr <= n_wr + 1;
      end else begin
        rd_q <= mem[wb.wb_adr_o[11:2]];
        n_rd <= n_rd + 1;
      end
    end
    if (wb.wb_stb_o) n_stb <= n_stb + 1;
    if (wb.wb_stb_o && !wb.wb_ack_i) wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
    if (prev_stall && ({wb.wb_stb_o, wb.wb_we_o, wb.wb_adr_o, wb.wb_dat_o} != prev_snap))
      unstable <= unstable + 1;
    prev_stall <= wb.wb_stb_o && !wb.wb_ack_i && !rst;
    prev_snap  <= {wb.wb_stb_o, wb.wb_we_o, wb.wb_adr_o, wb.wb_dat_o};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one access from an IDLE cycle; lat counts cycles after the sample edge.
  task automatic cpu_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic mis, output logic [31:0] rd);
    cpu_req      = 1'b1;
    cpu_we       = we;
    cpu_size     = size;
    cpu_unsigned = uns;
    cpu_addr     = addr;
    cpu_wdata    = wdata;
    lat = 0;
    mis = 1'b0;
    rd  = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin
        lat = i;
        mis = cpu_misalign;
        rd  = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
  endtask

  int          lat;
  logic        mis;
  logic [31:0] rd;
  int          wr0, rd0, stb0;
  logic        seen_ready;

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_unsigned = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stb", {31'b0, wb.wb_stb_o}, 32'h0);
    chk("rst_we", {31'b0, wb.wb_we_o}, 32'h0);
    chk("rst_ready", {31'b0, cpu_ready}, 32'h0);
    chk("rst_misalign", {31'b0, cpu_misalign}, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_adr", wb.wb_adr_o, 32'h0);
    chk("rst_dat", wb.wb_dat_o, 32'h0);
    rst = 1'b0; mem_init = 1'b0;
    @(posedge clk); #1;

    // Loads from 0x100 = 0x8899AABB
    cpu_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, lat, mis, rd);
    chk("lb_103", rd, 32'hFFFFFF88);
    chk("lb_lat", lat, 32'd3);
    chk("lb_mis", {31'b0, mis}, 32'h0);
    chk("ready_pulse", {31'b0, cpu_ready}, 32'h0);
    cpu_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, mis, rd);
    chk("lbu_103", rd, 32'h00000088);
    cpu_access(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, lat, mis, rd);
    chk("lb_101", rd, 32'hFFFFFFAA);
    cpu_access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, lat, mis, rd);
    chk("lh_102", rd, 32'hFFFF8899);
    cpu_access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, lat, mis, rd);
    chk("lhu_102", rd, 32'h00008899);
    cpu_access(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, lat, mis, rd);
    chk("lh_100", rd, 32'hFFFFAABB);
    cpu_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, mis, rd);
    chk("lw_100", rd, 32'h8899AABB);
    chk("lw_lat", lat, 32'd3);

    // Byte store via read-modify-write
    wr0 = n_wr; rd0 = n_rd; stb0 = n_stb;
    cpu_access(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A, lat, mis, rd);
    chk("sb_lat", lat, 32'd4);
    chk("sb_mis", {31'b0, mis}, 32'h0);
    chk("sb_mem", mem[64], 32'h88995ABB);
    chk("sb_strobes", n_stb - stb0, 32'd2);
    chk("sb_writes", n_wr - wr0, 32'd1);
    chk("sb_reads", n_rd - rd0, 32'd1);
    chk("rdata_hold", cpu_rdata, 32'h8899AABB);

    // Misaligned half and word stores
    stb0 = n_stb;
    cpu_access(1'b1, 2'b01, 1'b0, 32'h103, 32'h00001234, lat, mis, rd);
    chk("sh_mis_lat", lat, 32'd1);
    chk("sh_mis_flag", {31'b0, mis}, 32'h1);
    chk("sh_mis_stb", n_stb - stb0, 32'd0);
    chk("sh_mis_mem", mem[64], 32'h88995ABB);
    cpu_access(1'b1, 2'b10, 1'b0, 32'h102, 32'h12345678, lat, mis, rd);
    chk("sw_mis_lat", lat, 32'd1);
    chk("sw_mis_flag", {31'b0, mis}, 32'h1);
    chk("sw_mis_stb", n_stb - stb0, 32'd0);
    chk("sw_mis_mem", mem[64], 32'h88995ABB);

    // Word store with the slave stalling three cycles
    stall_len = 3;
    wr0 = n_wr;
    cpu_access(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, lat, mis, rd);
    stall_len = 0;
    chk("sw_stall_lat", lat, 32'd5);
    chk("sw_stall_writes", n_wr - wr0, 32'd1);
    chk("sw_stall_mem", mem[128], 32'hDEADBEEF);
    chk("stall_stable", unstable, 32'd0);

    // Reset in the middle of a byte store's read phase
    stall_len = 10;
    wr0 = n_wr;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b00; cpu_unsigned = 1'b0;
    cpu_addr = 32'h100; cpu_wdata = 32'h00000077;
    @(posedge clk); #1;
    chk("rmw_rd_stb", {31'b0, wb.wb_stb_o}, 32'h1);
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("abort_stb", {31'b0, wb.wb_stb_o}, 32'h0);
    rst = 1'b0; stall_len = 0;
    seen_ready = cpu_ready;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      seen_ready = seen_ready | cpu_ready;
    end
    chk("abort_no_ready", {31'b0, seen_ready}, 32'h0);
    chk("abort_no_write", n_wr - wr0, 32'd0);
    chk("abort_mem", mem[64], 32'h88995ABB);
    cpu_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, mis, rd);
    chk("post_rst_lw", rd, 32'h88995ABB);
    chk("post_rst_lat", lat, 32'd3);

    // Upper-half store and read-back
    cpu_access(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000CAFE, lat, mis, rd);
    chk("sh_lat", lat, 32'd4);
    chk("sh_mem", mem[64], 32'hCAFE5ABB);
    cpu_access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, lat, mis, rd);
    chk("lhu_cafe", rd, 32'h0000CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
